// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad (Pmod KYPD layout) one column at a
// time. The block synchronizes and debounces the row returns, decodes a single
// pressed key into a hex code, and emits a one-cycle strobe per accepted press.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   row[3:0]   in   row returns, active-low, asynchronous to clk
//   col[3:0]   out  column drive, active-low, exactly one bit low
//   key_code   out  hex code of the last accepted key (held)
//   key_valid  out  one-cycle pulse when a press is accepted
//   key_held   out  high from acceptance until debounced release
//   multi_key  out  high if the last completed frame saw two or more keys
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV = 100000,
  parameter int DB_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int                 DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int                 CNT_W    = (DB_SCANS > 0) ? $clog2(DB_SCANS + 1) : 1;
  localparam logic [CNT_W-1:0]   DB_MAX   = CNT_W'(DB_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  // Snapshot bit index is {column, row}; map it to the printed key legend.
  function automatic logic [3:0] decode_key(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h4;
      4'd2:  code = 4'h7;
      4'd3:  code = 4'h0;
      4'd4:  code = 4'h2;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h8;
      4'd7:  code = 4'hF;
      4'd8:  code = 4'h3;
      4'd9:  code = 4'h6;
      4'd10: code = 4'h9;
      4'd11: code = 4'hE;
      4'd12: code = 4'hA;
      4'd13: code = 4'hB;
      4'd14: code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Scan path state
  logic [3:0]       sync1_q, sync2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [15:0]      snap_q, snap_d;

  // Debounce / decode state
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             multi_key_q, multi_key_d;

  // Frame evaluation
  logic [3:0]       pressed;
  logic             sample;
  logic             frame_end;
  logic             is_none;
  logic             is_one;
  logic             is_multi;
  logic [3:0]       frame_key;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] rel_inc;

  always_comb begin
    pressed   = ~sync2_q;
    sample    = (div_q == DIV_LAST);
    frame_end = sample && (col_idx_q == 2'd3);

    div_d     = sample ? '0 : div_q + 1'b1;
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
    col_d     = ~(4'b0001 << col_idx_d);

    // snap_d already carries column 3's rows on the frame-end cycle, so the
    // frame is classified from it without waiting an extra cycle.
    snap_d = snap_q;
    if (sample) snap_d[{col_idx_q, 2'b00} +: 4] = pressed;

    is_none   = (snap_d == 16'd0);
    is_one    = !is_none && ((snap_d & (snap_d - 16'd1)) == 16'd0);
    is_multi  = !is_none && !is_one;
    frame_key = decode_key(onehot_to_idx(snap_d));
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    cnt_inc     = (cnt_q == DB_MAX) ? cnt_q : cnt_q + 1'b1;
    rel_inc     = (rel_q == DB_MAX) ? rel_q : rel_q + 1'b1;

    if (frame_end) begin
      multi_key_d = is_multi;
      case (state_q)
        ST_IDLE: begin
          if (is_one) begin
            cand_d = frame_key;
            if (DB_SCANS <= 1) begin
              key_code_d  = frame_key;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              rel_d       = '0;
              state_d     = ST_HELD;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (is_one && (frame_key == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              rel_d       = '0;
              state_d     = ST_HELD;
            end
          end else begin
            // Any disturbance restarts the debounce from scratch.
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (is_none) begin
            rel_d = rel_inc;
            if (rel_inc == DB_MAX) begin
              key_held_d = 1'b0;
              rel_d      = '0;
              state_d    = ST_IDLE;
            end
          end else begin
            rel_d = '0;
          end
        end
        default: begin
          cnt_d   = '0;
          rel_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      div_q       <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      snap_q      <= 16'd0;
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      rel_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      sync1_q     <= row;
      sync2_q     <= sync1_q;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      snap_q      <= snap_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner with SCAN_DIV=4, DB_SCANS=2 (16-cycle
// frame). A keypad model pulls row r low while col[c] is low and key (c,r)
// is pressed; keys[c*4+r] = 1 means pressed.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB_SCANS = 2;

  logic        clk;
  logic        reset_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;

  logic [15:0] keys;
  int          n_vec;
  int          n_err;
  int          vld_cnt;
  int          held_cnt;
  logic [3:0]  last_code;

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DB_SCANS (DB_SCANS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[c*4 + r] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Strobe / held monitor, sampled on the inactive edge
  initial begin
    vld_cnt   = 0;
    held_cnt  = 0;
    last_code = 4'd0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      vld_cnt   <= vld_cnt + 1;
      last_code <= key_code;
    end
    if (key_held) held_cnt <= held_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_held(input logic lvl, input int maxc, input string tag);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (key_held == lvl) break;
    end
    chk(tag, 16'(key_held), 16'(lvl));
  endtask

  task automatic wait_vld(input int base, input int maxc, input string tag);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (vld_cnt > base) break;
    end
    chk(tag, 16'(vld_cnt > base), 16'd1);
  endtask

  task automatic wait_col(input logic [3:0] target, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col == target) break;
    end
    chk(tag, 16'(col), 16'(target));
  endtask

  int base_v;
  int base_h;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    keys    = 16'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_col",   16'(col),       16'h000E);
    chk("rst_code",  16'(key_code),  16'd0);
    chk("rst_valid", 16'(key_valid), 16'd0);
    chk("rst_held",  16'(key_held),  16'd0);
    chk("rst_multi", 16'(multi_key), 16'd0);

    // Column sequence: each column low for 4 cycles starting at column 0
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] exp_col;
      @(posedge clk);
      #1;
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      chk($sformatf("col_seq%0d", k), 16'(col), 16'(exp_col));
    end

    // Idle: nothing happens with no key
    repeat (48) @(negedge clk);
    chk("idle_vld",   16'(vld_cnt),   16'd0);
    chk("idle_held",  16'(key_held),  16'd0);
    chk("idle_multi", 16'(multi_key), 16'd0);

    // Key (c1,r1) -> 5
    base_v = vld_cnt;
    keys   = 16'd1 << (1*4 + 1);
    wait_held(1'b1, 80, "k5_held_up");
    repeat (32) @(negedge clk);
    chk("k5_pulses", 16'(vld_cnt - base_v), 16'd1);
    chk("k5_code",   16'(key_code),         16'h5);
    chk("k5_strobe", 16'(last_code),        16'h5);
    keys = 16'd0;
    wait_held(1'b0, 52, "k5_release");
    repeat (48) @(negedge clk);
    chk("k5_no_more", 16'(vld_cnt - base_v), 16'd1);

    // Key (c3,r3) -> D, then add (c0,r0) while held
    base_v = vld_cnt;
    keys   = 16'd1 << (3*4 + 3);
    wait_held(1'b1, 80, "kD_held_up");
    repeat (4) @(negedge clk);
    chk("kD_code", 16'(key_code), 16'hD);
    keys = keys | 16'd1;
    repeat (40) @(negedge clk);
    chk("kD_multi",  16'(multi_key),        16'd1);
    chk("kD_pulses", 16'(vld_cnt - base_v), 16'd1);
    chk("kD_keep",   16'(key_code),         16'hD);
    chk("kD_held",   16'(key_held),         16'd1);
    keys = 16'd0;
    wait_held(1'b0, 80, "kD_release");
    repeat (40) @(negedge clk);
    chk("kD_multi_clr", 16'(multi_key), 16'd0);

    // One-frame tap of (c0,r3): rejected
    base_v = vld_cnt;
    base_h = held_cnt;
    keys   = 16'd1 << (0*4 + 3);
    repeat (16) @(negedge clk);
    keys = 16'd0;
    repeat (64) @(negedge clk);
    chk("tap_pulses", 16'(vld_cnt - base_v),  16'd0);
    chk("tap_held",   16'(held_cnt - base_h), 16'd0);

    // (c1,r0)+(c2,r0) together, then drop (c2,r0) -> 2
    base_v = vld_cnt;
    keys   = (16'd1 << (1*4 + 0)) | (16'd1 << (2*4 + 0));
    repeat (48) @(negedge clk);
    chk("two_multi",  16'(multi_key),        16'd1);
    chk("two_pulses", 16'(vld_cnt - base_v), 16'd0);
    keys = 16'd1 << (1*4 + 0);
    wait_vld(base_v, 80, "k2_strobe_seen");
    chk("k2_code",   16'(last_code), 16'h2);
    repeat (2) @(negedge clk);
    chk("k2_multi_clr", 16'(multi_key), 16'd0);
    keys = 16'd0;
    wait_held(1'b0, 80, "k2_release");

    // (c2,r3) -> E with a reset in the middle of debounce
    wait_col(4'b0111, "align_c3");
    wait_col(4'b1110, "align_c0");
    base_v = vld_cnt;
    keys   = 16'd1 << (2*4 + 3);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_col",   16'(col),       16'h000E);
    chk("mid_rst_code",  16'(key_code),  16'd0);
    chk("mid_rst_valid", 16'(key_valid), 16'd0);
    chk("mid_rst_held",  16'(key_held),  16'd0);
    chk("mid_rst_multi", 16'(multi_key), 16'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_no_vld", 16'(vld_cnt - base_v), 16'd0);
    reset_n = 1'b1;
    wait_vld(base_v, 80, "kE_strobe_seen");
    chk("kE_code", 16'(last_code), 16'hE);
    repeat (64) @(negedge clk);
    chk("kE_pulses", 16'(vld_cnt - base_v), 16'd1);
    chk("kE_held",   16'(key_held),         16'd1);
    keys = 16'd0;
    wait_held(1'b0, 80, "kE_release");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart to the multiplexed 7-segment display controller: this block drives a 4x4 matrix keypad (Pmod KYPD layout) one column at a time and reads the row lines back. It synchronizes and debounces the matrix, then decodes a single pressed key into a 4-bit hex code. It emits a one-cycle strobe per accepted press, which can feed the counter/display path in place of a switch pulse.

## Interface
- SCAN_DIV, 100000: clock cycles each column is driven (1 ms at 100 MHz); must be ≥ 4.
- DB_SCANS, 4: number of consecutive identical full frames required to accept a press or a release; must be ≥ 1.
- clk  in  1  system clock; all flops rise-edge.
- reset_n  in  1  asynchronous, active-low reset.
- row  in  4  keypad row lines, active-low (pulled up externally); asynchronous to clk.
- col  out  4  column drive, active-low, exactly one bit low at all times.
- key_code  out  4  hex code of last accepted key; held until next acceptance.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_held  out  1  high from acceptance until debounced release.
- multi_key  out  1  high if the most recent completed frame saw ≥2 keys.

## Operation
- Row input: two-flop synchronizer per bit, then inverted, so 1 = pressed.
- Column sequencer:
  - The divider counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, the synchronized rows are stored into the 4-bit slice of a 16-bit frame snapshot for the current column.
  - The column index then advances 0→1→2→3→0.
  - col = ~(1 << index).
- Frame end: the sample cycle of column 3. The snapshot is evaluated as one of:
  - NONE: 0 bits set.
  - ONE(K): exactly 1 bit set.
  - MULTI: ≥2 bits set.
- Decode (column, row 0..3 top to bottom):
  - c0 → 1,4,7,0
  - c1 → 2,5,8,F
  - c2 → 3,6,9,E
  - c3 → A,B,C,D
- FSM, evaluated only at frame end:
  - IDLE:
    - ONE(K): cand←K, cnt←1, go CONFIRM. If DB_SCANS=1, accept immediately and go HELD.
    - NONE/MULTI: stay.
  - CONFIRM:
    - ONE(cand): cnt++. When cnt reaches DB_SCANS, accept and go HELD.
    - Any other result (different key, NONE, MULTI): cnt←0, go IDLE.
  - Accept: key_code←cand, key_valid pulse, key_held←1.
  - HELD:
    - NONE: rel++. When rel reaches DB_SCANS, key_held←0, rel←0, go IDLE.
    - Any non-NONE result: rel←0 and stay. No second key_valid while held; a second key is ignored until full release.
- multi_key is updated every frame end (1 for MULTI, else 0). It is independent of FSM state.
- Counters: the divider is sized to fit SCAN_DIV-1. cnt and rel are sized to fit DB_SCANS and saturate.

## Timing
- Reset values (asynchronous, immediate):
  - col=4'b1110, divider=0, snapshot=0.
  - key_code=0, key_valid=0, key_held=0, multi_key=0.
  - FSM=IDLE, cnt=rel=0.
  - Synchronizer flops reset to 1111 (no key).
- Frame length: 4·SCAN_DIV cycles.
- The row sample uses the synchronizer output at divider=SCAN_DIV-1. The column has therefore been stable ≥ SCAN_DIV-2 cycles, which is the settle margin.
- Outputs are registered and update on the clock edge ending the frame-end cycle. key_valid is high for exactly that following cycle.
- Press-to-key_valid latency: between (DB_SCANS-1)·4·SCAN_DIV and (DB_SCANS+1)·4·SCAN_DIV cycles, plus 3 cycles of sync/registration.
- Release-to-key_held-low latency: same bound.
- Reset mid-scan or mid-debounce: all state is discarded, and scanning restarts at column 0 on the first edge after deassertion. A key still held after reset is treated as a new press and produces one key_valid once debounced.
- Bounce shorter than one frame within CONFIRM returns the FSM to IDLE; there is no partial credit.

## Test plan
Sim parameters: SCAN_DIV=4, DB_SCANS=2, frame=16 cycles. A keypad model pulls row r low when col[c] is low and key (c,r) is pressed.
- After reset: col cycles 1110,1101,1011,0111, each for 4 cycles. All other outputs stay 0 with no key pressed.
- Hold key (c1,r1) steady → exactly one key_valid pulse with key_code=5, and key_held=1. key_held drops to 0 within 3 frames of release. No further pulses.
- Hold (c3,r3) → key_code=D. Then, without release, add (c0,r0) → multi_key=1 on the next frame end, no new key_valid, and key_code remains D.
- Press (c0,r3) for a single frame only, then release → no key_valid, key_held stays 0.
- Press (c1,r0) and (c2,r0) together from IDLE → multi_key=1 and no key_valid. Release (c2,r0) → key_valid with key_code=2 after 2 clean frames.
- Hold (c2,r3), assert reset_n=0 mid-CONFIRM for 3 cycles, then release reset → outputs return to reset values immediately. One key_valid with key_code=E then follows, with no duplicate pulse.
